// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing defaults and noise LFSR constants
package video_timing_pkg;

  localparam int DEF_CE_DIV       = 8;
  localparam int DEF_H_ACTIVE     = 256;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 32;
  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_V_ACTIVE     = 192;
  localparam int DEF_V_SYNC       = 3;
  localparam int DEF_V_FP_NTSC    = 24;
  localparam int DEF_V_TOTAL_NTSC = 262;
  localparam int DEF_V_FP_PAL     = 48;
  localparam int DEF_V_TOTAL_PAL  = 312;
  localparam int DEF_PIX_W        = 8;

  // Fibonacci LFSR, taps 16,14,13,11 counted from the output end (bits 0,2,3,5)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/ce_divider.sv
// rtl/ce_divider.sv - pixel clock-enable divider, full or half rate selectable at runtime
module ce_divider #(
  parameter int CE_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_half,
  output logic o_wrap,
  output logic o_ce
);

  localparam int CW = $clog2(CE_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CE_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic          r_ce;
  logic [CW-1:0] w_last;

  // >= rather than == so a rate switch can never strand the counter past its new limit
  always_comb begin
    w_last = i_half ? HALF_LAST : FULL_LAST;
    o_wrap = (r_cnt >= w_last);
  end

  // free-running divider; the enable is registered from the wrap condition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= o_wrap;
      r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator, NTSC/PAL, 15/31 kHz (option: VIDEO_TIMING_GEN_NOISE_EN)
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV       = DEF_CE_DIV,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_FP_NTSC    = DEF_V_FP_NTSC,
  parameter int V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
  parameter int V_FP_PAL     = DEF_V_FP_PAL,
  parameter int V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
  parameter int PIX_W        = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pal,
  input  logic             scandouble,
  output logic             ce_pix,
  output logic [8:0]       hcount,
  output logic [9:0]       vcount,
  output logic             HBlank,
  output logic             HSync,
  output logic             VBlank,
  output logic             VSync,
  output logic             frame_start,
  output logic [PIX_W-1:0] video
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_ON    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA_BASE  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BASE  = 10'(V_SYNC);
  localparam logic [9:0] VT_NTSC  = 10'(V_TOTAL_NTSC);
  localparam logic [9:0] VT_PAL   = 10'(V_TOTAL_PAL);
  localparam logic [9:0] VFP_NTSC = 10'(V_FP_NTSC);
  localparam logic [9:0] VFP_PAL  = 10'(V_FP_PAL);

  logic             r_pal;
  logic             r_sd;
  logic [8:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hblank;
  logic             r_hsync;
  logic             r_vblank;
  logic             r_vsync;
  logic             r_fs;
  logic [PIX_W-1:0] r_video;

  logic       w_ce;
  logic       w_div_wrap;
  logic [9:0] w_vt_base;
  logic [9:0] w_vfp_base;
  logic [9:0] w_vt;
  logic [9:0] w_va;
  logic [9:0] w_vfp;
  logic [9:0] w_vs;
  logic [9:0] w_vs_on;
  logic [9:0] w_vs_off;
  logic [9:0] w_h10;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame_end;
  logic       w_active_next;

  // the divider follows the latched mode, so a rate change lands exactly at a frame edge
  ce_divider #(
    .CE_DIV (CE_DIV)
  ) u_ce_divider (
    .clk    (clk),
    .reset  (reset),
    .i_half (r_sd),
    .o_wrap (w_div_wrap),
    .o_ce   (w_ce)
  );

  // vertical geometry of the frame in progress; 31 kHz doubles every line figure
  always_comb begin
    w_vt_base  = r_pal ? VT_PAL : VT_NTSC;
    w_vfp_base = r_pal ? VFP_PAL : VFP_NTSC;
    if (r_sd) begin
      w_vt  = w_vt_base << 1;
      w_va  = VA_BASE << 1;
      w_vfp = w_vfp_base << 1;
      w_vs  = VS_BASE << 1;
    end else begin
      w_vt  = w_vt_base;
      w_va  = VA_BASE;
      w_vfp = w_vfp_base;
      w_vs  = VS_BASE;
    end
    w_vs_on  = w_va + w_vfp;
    w_vs_off = w_vs_on + w_vs;
  end

  // raster position the counters move to on the next pixel enable
  always_comb begin
    w_h10    = {1'b0, r_h};
    w_h_last = (w_h10 == H_LAST);
    w_v_last = (r_v == w_vt - 10'd1);
    w_h_next = w_h_last ? 10'd0 : w_h10 + 10'd1;
    w_v_next = r_v;
    if (w_h_last) begin
      w_v_next = w_v_last ? 10'd0 : r_v + 10'd1;
    end
    w_frame_end   = w_ce && w_h_last && w_v_last;
    w_active_next = (w_h_next < H_ACT) && (w_v_next < w_va);
  end

  // mode inputs are only taken at the last pixel of a frame so a frame never changes shape
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pal <= pal;
      r_sd  <= scandouble;
    end else if (w_frame_end) begin
      r_pal <= pal;
      r_sd  <= scandouble;
    end
  end

  // pixel and line counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_ce) begin
      r_h <= w_h_next[8:0];
      r_v <= w_v_next;
    end
  end

  // blank/sync flags decoded from the next position so they move with the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
    end else if (w_ce) begin
      r_hblank <= (w_h_next >= H_ACT);
      r_hsync  <= (w_h_next >= HS_ON) && (w_h_next < HS_OFF);
      r_vblank <= (w_v_next >= w_va);
      r_vsync  <= (w_v_next >= w_vs_on) && (w_v_next < w_vs_off);
    end
  end

  // frame_start rides along with the enable of pixel 0,0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs <= 1'b0;
    end else begin
      r_fs <= w_div_wrap && (r_h == 9'd0) && (r_v == 10'd0);
    end
  end

`ifdef VIDEO_TIMING_GEN_NOISE_EN
  logic [15:0] r_lfsr;

  // noise pattern: one LFSR step per displayed pixel, seed shown on the first one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr  <= LFSR_SEED;
      r_video <= '0;
    end else if (w_ce) begin
      if (w_active_next) begin
        r_video <= r_lfsr[PIX_W-1:0];
        r_lfsr  <= lfsr_step(r_lfsr);
      end else begin
        r_video <= '0;
      end
    end
  end
`else
  // ramp pattern: pixel value is the horizontal position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_video <= '0;
    end else if (w_ce) begin
      r_video <= w_active_next ? PIX_W'(w_h_next) : '0;
    end
  end
`endif

  assign ce_pix      = w_ce;
  assign hcount      = r_h;
  assign vcount      = r_v;
  assign HBlank      = r_hblank;
  assign HSync       = r_hsync;
  assign VBlank      = r_vblank;
  assign VSync       = r_vsync;
  assign frame_start = r_fs;
  assign video       = r_video;

endmodule
